// File: rtl/adder_response_checker_if.sv
// -----------------------------------------------------------------------------
// adder_response_checker_if
// Bundles one applied adder vector with the adder's response so the stimulus
// side and the checker pass a single handle around.
//   in_valid  : in_a/in_b/in_ci/dut_s/dut_co carry a vector this cycle
//   in_a/in_b : operands applied to the adder (WIDTH bits)
//   in_ci     : carry-in applied
//   dut_s     : adder sum output (WIDTH bits)
//   dut_co    : adder carry-out
// Modports: master drives the vector, slave (the checker) receives it.
// -----------------------------------------------------------------------------
interface adder_response_checker_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic [WIDTH-1:0] dut_s;
    logic             dut_co;

    modport master (
        output in_valid, in_a, in_b, in_ci, dut_s, dut_co
    );

    modport slave (
        input in_valid, in_a, in_b, in_ci, dut_s, dut_co
    );
endinterface

// File: rtl/adder_response_checker.sv
// -----------------------------------------------------------------------------
// adder_response_checker
// Response end for the carry-lookahead adder. Each accepted vector {a,b,ci}
// is compared against the adder's {co,s} in a two-stage pipeline: stage 1
// captures the vector, stage 2 computes the golden sum and commits the
// verdict into saturating pass/fail counters. The first failing vector of a
// run is latched for debug, and done is raised once every expected vector
// has been compared.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   start              : 1-cycle pulse, clears results, loads num_vectors
//   num_vectors        : vectors expected this run (COUNT_W bits)
//   vec                : slave side of the vector/response bundle
//   busy / done        : run in progress / run finished (level)
//   pass_count         : matching vectors, saturating
//   fail_count         : mismatching vectors, saturating
//   fail_seen          : at least one mismatch this run
//   ff_a, ff_b, ff_ci  : operands of the first failure
//   ff_s, ff_co        : adder result of the first failure
// -----------------------------------------------------------------------------
module adder_response_checker #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_W-1:0]     num_vectors,
    adder_response_checker_if.slave vec,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_W-1:0]     pass_count,
    output logic [COUNT_W-1:0]     fail_count,
    output logic                   fail_seen,
    output logic [WIDTH-1:0]       ff_a,
    output logic [WIDTH-1:0]       ff_b,
    output logic                   ff_ci,
    output logic [WIDTH-1:0]       ff_s,
    output logic                   ff_co
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state, state_next;
    logic [COUNT_W-1:0] num_q;
    logic [COUNT_W-1:0] accepted;
    logic               accept;
    logic               last_accept;

    logic               vld_p1;
    logic [WIDTH-1:0]   a_p1;
    logic [WIDTH-1:0]   b_p1;
    logic               ci_p1;
    logic [WIDTH-1:0]   s_p1;
    logic               co_p1;
    logic               match_p1;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // Reference sum at WIDTH+1 bits so the carry-out is part of the result.
    function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             ci);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    endfunction

    // start has priority over a vector presented in the same cycle.
    assign accept      = vec.in_valid && (state == RUN) && !start;
    assign last_accept = accept && ((accepted + ONE) == num_q);

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = (num_vectors == '0) ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (last_accept) state_next = DRAIN;
                DRAIN:   state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q    <= '0;
            accepted <= '0;
        end else if (start) begin
            num_q    <= num_vectors;
            accepted <= '0;
        end else if (accept) begin
            accepted <= accepted + ONE;
        end
    end

    // ---- stage 1: capture accepted vector and adder response ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            ci_p1  <= 1'b0;
            s_p1   <= '0;
            co_p1  <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                a_p1  <= vec.in_a;
                b_p1  <= vec.in_b;
                ci_p1 <= vec.in_ci;
                s_p1  <= vec.dut_s;
                co_p1 <= vec.dut_co;
            end
        end
    end

    assign match_p1 = ({co_p1, s_p1} == golden_sum(a_p1, b_p1, ci_p1));

    // ---- stage 2: compare and commit verdict ----
    // A start discards any vector still in stage 1 along with the old results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
            fail_seen  <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_ci      <= 1'b0;
            ff_s       <= '0;
            ff_co      <= 1'b0;
        end else if (start) begin
            pass_count <= '0;
            fail_count <= '0;
            fail_seen  <= 1'b0;
            ff_a       <= '0;
            ff_b       <= '0;
            ff_ci      <= 1'b0;
            ff_s       <= '0;
            ff_co      <= 1'b0;
        end else if (vld_p1) begin
            if (match_p1) begin
                pass_count <= sat_inc(pass_count);
            end else begin
                fail_count <= sat_inc(fail_count);
                fail_seen  <= 1'b1;
                if (!fail_seen) begin
                    ff_a  <= a_p1;
                    ff_b  <= b_p1;
                    ff_ci <= ci_p1;
                    ff_s  <= s_p1;
                    ff_co <= co_p1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_response_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_response_checker
// Directed bench for adder_response_checker: drives known vectors with
// hand-computed adder responses (some deliberately wrong) and checks the
// checker's counters, status and first-failure capture.
// -----------------------------------------------------------------------------
module tb_adder_response_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] num_vectors;
    logic        busy;
    logic        done;
    logic [31:0] pass_count;
    logic [31:0] fail_count;
    logic        fail_seen;
    logic [15:0] ff_a;
    logic [15:0] ff_b;
    logic        ff_ci;
    logic [15:0] ff_s;
    logic        ff_co;

    int tests_run;
    int tests_failed;

    adder_response_checker_if #(.WIDTH(16)) vif ();

    adder_response_checker #(.WIDTH(16), .COUNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vectors (num_vectors),
        .vec         (vif),
        .busy        (busy),
        .done        (done),
        .pass_count  (pass_count),
        .fail_count  (fail_count),
        .fail_seen   (fail_seen),
        .ff_a        (ff_a),
        .ff_b        (ff_b),
        .ff_ci       (ff_ci),
        .ff_s        (ff_s),
        .ff_co       (ff_co)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] s, input logic co);
        vif.in_valid = 1'b1;
        vif.in_a     = a;
        vif.in_b     = b;
        vif.in_ci    = ci;
        vif.dut_s    = s;
        vif.dut_co   = co;
        step();
    endtask

    task automatic do_start(input logic [31:0] n);
        start       = 1'b1;
        num_vectors = n;
        step();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_vectors = '0;
        vif.in_valid = 1'b0; vif.in_a = '0; vif.in_b = '0; vif.in_ci = 1'b0;
        vif.dut_s = '0; vif.dut_co = 1'b0;
        step(); step();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
        tests_run++; if (pass_count !== 32'd0 || fail_count !== 32'd0) begin tests_failed++; $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, fail_count); end
        tests_run++; if (fail_seen !== 1'b0 || ff_a !== 16'h0 || ff_s !== 16'h0) begin tests_failed++; $display("FAIL reset_ff got %0b %h %h want 0 0000 0000", fail_seen, ff_a, ff_s); end
        rst = 1'b0;
        // Vectors offered in IDLE must be ignored.
        put(16'h0001, 16'h0001, 1'b0, 16'h0005, 1'b0);
        put(16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0);
        vif.in_valid = 1'b0;
        step(); step();
        tests_run++; if (pass_count !== 32'd0 || fail_count !== 32'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL idle_ignore got pass=%0d fail=%0d busy=%0b want 0 0 0", pass_count, fail_count, busy); end
    endtask

    task automatic test_basic();
        do_start(32'd3);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got %0b want 1", busy); end
        put(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        put(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        put(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        vif.in_valid = 1'b0;
        // Just after the final accept edge: last compare not yet committed.
        tests_run++; if (done !== 1'b0 || busy !== 1'b1 || pass_count !== 32'd2) begin tests_failed++; $display("FAIL basic_drain got done=%0b busy=%0b pass=%0d want 0 1 2", done, busy, pass_count); end
        step();
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL basic_done got done=%0b busy=%0b want 1 0", done, busy); end
        tests_run++; if (pass_count !== 32'd3 || fail_count !== 32'd0 || fail_seen !== 1'b0) begin tests_failed++; $display("FAIL basic_counts got pass=%0d fail=%0d seen=%0b want 3 0 0", pass_count, fail_count, fail_seen); end
        step();
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL basic_done_hold got %0b want 1", done); end
    endtask

    task automatic test_sweep();
        logic [16:0] sum;
        do_start(32'd65536);
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                sum = 17'(a) + 17'(b);
                put(16'(a), 16'(b), 1'b0, sum[15:0], sum[16]);
            end
        end
        vif.in_valid = 1'b0;
        step();
        tests_run++; if (pass_count !== 32'd65536 || fail_count !== 32'd0) begin tests_failed++; $display("FAIL sweep_counts got pass=%0d fail=%0d want 65536 0", pass_count, fail_count); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL sweep_done got %0b want 1", done); end
    endtask

    task automatic test_first_fail();
        do_start(32'd4);
        put(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        put(16'h0003, 16'h0004, 1'b0, 16'h0008, 1'b0);
        vif.in_valid = 1'b0;
        step();
        put(16'h0010, 16'h0020, 1'b1, 16'h0031, 1'b0);
        put(16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b1);
        vif.in_valid = 1'b0;
        step();
        tests_run++; if (pass_count !== 32'd2 || fail_count !== 32'd2) begin tests_failed++; $display("FAIL ff_counts got pass=%0d fail=%0d want 2 2", pass_count, fail_count); end
        tests_run++; if (ff_a !== 16'h0003 || ff_b !== 16'h0004 || ff_ci !== 1'b0) begin tests_failed++; $display("FAIL ff_operands got %h %h %0b want 0003 0004 0", ff_a, ff_b, ff_ci); end
        tests_run++; if (ff_s !== 16'h0008 || ff_co !== 1'b0 || fail_seen !== 1'b1) begin tests_failed++; $display("FAIL ff_result got s=%h co=%0b seen=%0b want 0008 0 1", ff_s, ff_co, fail_seen); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL ff_done got %0b want 1", done); end
    endtask

    task automatic test_carry_only();
        do_start(32'd1);
        put(16'h00FF, 16'hFF01, 1'b0, 16'h0000, 1'b0);
        vif.in_valid = 1'b0;
        step();
        tests_run++; if (fail_count !== 32'd1 || pass_count !== 32'd0) begin tests_failed++; $display("FAIL carry_counts got pass=%0d fail=%0d want 0 1", pass_count, fail_count); end
        tests_run++; if (ff_a !== 16'h00FF || ff_b !== 16'hFF01 || ff_s !== 16'h0000 || ff_co !== 1'b0) begin tests_failed++; $display("FAIL carry_ff got %h %h %h %0b want 00ff ff01 0000 0", ff_a, ff_b, ff_s, ff_co); end
    endtask

    task automatic test_zero_vectors();
        do_start(32'd0);
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL zero_done got done=%0b busy=%0b want 1 0", done, busy); end
        tests_run++; if (pass_count !== 32'd0 || fail_count !== 32'd0 || fail_seen !== 1'b0) begin tests_failed++; $display("FAIL zero_clear got pass=%0d fail=%0d seen=%0b want 0 0 0", pass_count, fail_count, fail_seen); end
        put(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
        put(16'h0001, 16'h0002, 1'b0, 16'h0009, 1'b0);
        vif.in_valid = 1'b0;
        step(); step();
        tests_run++; if (pass_count !== 32'd0 || fail_count !== 32'd0 || done !== 1'b1) begin tests_failed++; $display("FAIL done_ignore got pass=%0d fail=%0d done=%0b want 0 0 1", pass_count, fail_count, done); end
    endtask

    task automatic test_back_to_back();
        do_start(32'd3);
        put(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0);
        // Restart while the bad vector is in flight; the vector offered with start is also bad.
        start = 1'b1; num_vectors = 32'd1;
        put(16'h0007, 16'h0001, 1'b0, 16'h0000, 1'b0);
        start = 1'b0;
        tests_run++; if (fail_count !== 32'd0 || fail_seen !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL restart_clear got fail=%0d seen=%0b busy=%0b want 0 0 1", fail_count, fail_seen, busy); end
        put(16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0);
        vif.in_valid = 1'b0;
        step();
        tests_run++; if (pass_count !== 32'd1 || fail_count !== 32'd0 || done !== 1'b1) begin tests_failed++; $display("FAIL restart_result got pass=%0d fail=%0d done=%0b want 1 0 1", pass_count, fail_count, done); end
    endtask

    task automatic test_reset_mid_run();
        do_start(32'd10);
        put(16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0);
        put(16'h0002, 16'h0000, 1'b0, 16'h0007, 1'b0);
        put(16'h0003, 16'h0000, 1'b0, 16'h0003, 1'b0);
        put(16'h0004, 16'h0000, 1'b0, 16'h0004, 1'b0);
        put(16'h0005, 16'h0000, 1'b0, 16'h0005, 1'b0);
        vif.in_valid = 1'b0;
        tests_run++; if (pass_count !== 32'd3 || fail_count !== 32'd1 || fail_seen !== 1'b1) begin tests_failed++; $display("FAIL midrun_state got pass=%0d fail=%0d seen=%0b want 3 1 1", pass_count, fail_count, fail_seen); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || pass_count !== 32'd0 || fail_count !== 32'd0) begin tests_failed++; $display("FAIL async_reset got busy=%0b done=%0b pass=%0d fail=%0d want 0 0 0 0", busy, done, pass_count, fail_count); end
        tests_run++; if (fail_seen !== 1'b0 || ff_a !== 16'h0 || ff_s !== 16'h0) begin tests_failed++; $display("FAIL async_reset_ff got seen=%0b a=%h s=%h want 0 0000 0000", fail_seen, ff_a, ff_s); end
        step();
        rst = 1'b0;
        do_start(32'd2);
        put(16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0);
        put(16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1);
        vif.in_valid = 1'b0;
        step();
        tests_run++; if (pass_count !== 32'd2 || fail_count !== 32'd0 || done !== 1'b1) begin tests_failed++; $display("FAIL post_reset_run got pass=%0d fail=%0d done=%0b want 2 0 1", pass_count, fail_count, done); end
        tests_run++; if (fail_seen !== 1'b0 || ff_a !== 16'h0) begin tests_failed++; $display("FAIL post_reset_residue got seen=%0b a=%h want 0 0000", fail_seen, ff_a); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_sweep();
        test_first_fail();
        test_carry_only();
        test_zero_vectors();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
